// File: rtl/clm_aes_sched.sv
// ---------------------------------------------------------------------------
// clm_aes_sched
//
// Round-robin scheduler that shares one CLM AES core among NUM_REQ requesters.
// A granted request is latched into the core operand registers. A fresh
// 23-byte random vector is then generated from an internal 8-bit Galois LFSR.
// The core is started with a single drdy_i pulse, and the scheduler waits for
// a rising edge on drdy_o or for a timeout. The ciphertext (or an error) is
// returned tagged with the requester ID.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready per-requester handshake; req_ready is a one-hot grant
//   req_pt, req_key     NUM_REQ packed 128-bit operands, slice i = requester i
//   rsp_valid/rsp_ready response handshake
//   rsp_id, rsp_ct      answered requester ID and ciphertext
//   rsp_err             operation timed out, rsp_ct forced to zero
//   cfg_we, cfg_p_det   p_det configuration write, applied at next operation
//   busy                scheduler not idle
//   core_*              interface to clm_aes_multiple_sbox_limited_p
// ---------------------------------------------------------------------------
module clm_aes_sched #(
  parameter int         NUM_REQ     = 2,
  parameter int         TIMEOUT_CYC = 1023,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*128-1:0]   req_pt,
  input  logic [NUM_REQ*128-1:0]   req_key,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [2:0]               rsp_id,
  output logic [127:0]             rsp_ct,
  output logic                     rsp_err,
  input  logic                     cfg_we,
  input  logic [4:0]               cfg_p_det,
  output logic                     busy,
  output logic                     core_drdy_i,
  output logic [127:0]             core_plaintext,
  output logic [127:0]             core_key,
  output logic [4:0]               core_p_det,
  output logic [22:0][7:0]         core_random_vect,
  input  logic                     core_drdy_o,
  input  logic [127:0]             core_ciphertext
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REFRESH,
    S_START,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        state;
  logic [2:0]    rr_ptr;
  logic [2:0]    cur_id;
  logic [7:0]    lfsr;
  logic [4:0]    p_det_cfg;
  logic [4:0]    k_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          prev_drdy;

  logic          grant_hit;
  logic [2:0]    grant_id;
  logic          accept;
  logic [127:0]  sel_pt;
  logic [127:0]  sel_key;
  logic [7:0]    lfsr_next;

  // Position of the off-th candidate in the cyclic search starting at base.
  // base is always below NUM_REQ, so one subtraction is enough to wrap.
  function automatic int wrap_idx(input logic [2:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s;
  endfunction

  // x^8 = x^6 + x^5 + x^4 + 1, so a carry out of bit 7 folds back as 8'h71.
  assign lfsr_next = {lfsr[6:0], 1'b0} ^ (lfsr[7] ? 8'h71 : 8'h00);

  // Round-robin grant: the first valid requester at or after rr_ptr wins.
  // The search is written against constant indices so no variable-width
  // select is needed on req_valid.
  always_comb begin
    req_ready = '0;
    grant_id  = '0;
    grant_hit = 1'b0;
    if (state == S_IDLE) begin
      for (int off = 0; off < NUM_REQ; off++) begin
        for (int j = 0; j < NUM_REQ; j++) begin
          if (!grant_hit && (wrap_idx(rr_ptr, off) == j) && req_valid[j]) begin
            grant_hit    = 1'b1;
            grant_id     = 3'(j);
            req_ready[j] = 1'b1;
          end
        end
      end
    end
  end

  assign accept = |(req_valid & req_ready);

  // Operand mux driven by the one-hot grant.
  always_comb begin
    sel_pt  = '0;
    sel_key = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (req_ready[j]) begin
        sel_pt  = req_pt[j*128 +: 128];
        sel_key = req_key[j*128 +: 128];
      end
    end
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= S_IDLE;
      rr_ptr           <= '0;
      cur_id           <= '0;
      lfsr             <= LFSR_SEED;
      p_det_cfg        <= 5'd15;
      k_cnt            <= '0;
      tmo_cnt          <= '0;
      prev_drdy        <= 1'b0;
      core_drdy_i      <= 1'b0;
      core_plaintext   <= '0;
      core_key         <= '0;
      core_p_det       <= 5'd15;
      core_random_vect <= {23{8'd109}};
      rsp_valid        <= 1'b0;
      rsp_id           <= '0;
      rsp_ct           <= '0;
      rsp_err          <= 1'b0;
    end else begin
      // Configuration is shadowed here and only reaches the core when the
      // next operation starts.
      if (cfg_we) p_det_cfg <= cfg_p_det;

      unique case (state)
        S_IDLE: begin
          if (accept) begin
            core_plaintext <= sel_pt;
            core_key       <= sel_key;
            core_p_det     <= p_det_cfg;
            cur_id         <= grant_id;
            rr_ptr         <= (grant_id == 3'(NUM_REQ - 1)) ? 3'd0 : grant_id + 3'd1;
            k_cnt          <= '0;
            state          <= S_REFRESH;
          end
        end

        S_REFRESH: begin
          // A zero byte is never handed to the core.
          core_random_vect[k_cnt] <= (lfsr == 8'h00) ? 8'h01 : lfsr;
          lfsr                    <= lfsr_next;
          if (k_cnt == 5'd22) begin
            k_cnt       <= '0;
            core_drdy_i <= 1'b1;
            state       <= S_START;
          end else begin
            k_cnt <= k_cnt + 5'd1;
          end
        end

        S_START: begin
          // drdy_o may still be high from the previous operation, so only a
          // fresh rising edge after this point counts as completion.
          core_drdy_i <= 1'b0;
          prev_drdy   <= core_drdy_o;
          tmo_cnt     <= '0;
          state       <= S_WAIT;
        end

        S_WAIT: begin
          prev_drdy <= core_drdy_o;
          if (core_drdy_o && !prev_drdy) begin
            rsp_ct    <= core_ciphertext;
            rsp_err   <= 1'b0;
            rsp_id    <= cur_id;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
            rsp_ct    <= '0;
            rsp_err   <= 1'b1;
            rsp_id    <= cur_id;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
